muldiv_unit: RTL and testbench

- Multi-cycle RV32M execute unit with XLEN as a parameter.
- Sits beside the ALU in the execute stage. The pipeline issues MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU through a start/done handshake and stalls while busy is high.
- Multiply is a single registered cycle. Divide is a radix-2 restoring iteration of XLEN cycles. Division corner cases bypass the iteration.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_div_core.sv | 74 +++++++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide execute unit.
//   - FN_* : func3 encodings of the eight M-extension operations
//   - state_t : control FSM state encoding (3 bits)
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [2:0] FN_MUL    = 3'b000;
    localparam logic [2:0] FN_MULH   = 3'b001;
    localparam logic [2:0] FN_MULHSU = 3'b010;
    localparam logic [2:0] FN_MULHU  = 3'b011;
    localparam logic [2:0] FN_DIV    = 3'b100;
    localparam logic [2:0] FN_DIVU   = 3'b101;
    localparam logic [2:0] FN_REM    = 3'b110;
    localparam logic [2:0] FN_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// -----------------------------------------------------------------------------
// muldiv_div_core
// Radix-2 restoring divider on unsigned magnitudes. One quotient bit is
// produced per step; XLEN steps complete a division.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   load                capture dividend/divisor and restart the counter
//   step                perform one iteration
//   dividend, divisor   unsigned magnitudes (XLEN)
//   quotient, remainder unsigned results, valid after the last step
//   last                high while the final iteration is being performed
// -----------------------------------------------------------------------------
import muldiv_pkg::*;

module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // The partial remainder is always below the divisor, so after the shift
    // it fits in XLEN+1 bits and the top bit of the difference is the borrow.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    // Dividend bits shift out of the quotient register's top as quotient
    // bits shift in at the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= CW'(XLEN - 1);
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle RV32M execute unit. Multiplies finish in one registered cycle,
// divides iterate XLEN cycles then fix up signs; divide-by-zero and signed
// overflow bypass the iteration and complete like a multiply.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           request valid, sampled only in IDLE or DONE
//   func3           RV32M operation select
//   op1, op2        rs1 / rs2 values
//   rd_in           destination index carried with the op
//   flush           synchronous kill of any in-flight op
//   busy            high in MUL, DIV, FIX
//   done            one-cycle result-valid pulse
//   result, rd_out  registered result and destination, held until next done
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [RD_W-1:0] rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    state_t          state_nxt;

    logic [2:0]      fn_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [RD_W-1:0] rd_q;

    logic            accept;
    logic            in_signed;
    logic            bypass;
    logic            load_div;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;

    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            div_last;

    logic            a_sx;
    logic            b_sx;
    logic [2*XLEN-1:0] a_w;
    logic [2*XLEN-1:0] b_w;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mul_res;
    logic [XLEN-1:0] corner_res;
    logic [XLEN-1:0] fix_res;
    logic            neg_q;
    logic            neg_r;

    // Request decode works on the raw inputs so the divider can be loaded
    // on the accepting edge and start iterating in cycle 1. Corner cases are
    // detected here so they never enter the iteration.
    always_comb begin
        accept    = ((state == ST_IDLE) || (state == ST_DONE)) && start && !flush;
        in_signed = ~func3[0];
        bypass    = (op2 == '0) || (in_signed && (op1 == MOST_NEG) && (op2 == '1));
        load_div  = accept && func3[2] && !bypass;
        mag1      = (in_signed && op1[XLEN-1]) ? -op1 : op1;
        mag2      = (in_signed && op2[XLEN-1]) ? -op2 : op2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Corner-case divides reuse the single-cycle MUL slot. flush overrides
    // everything, including a start in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_nxt = (func3[2] && !bypass) ? ST_DIV : ST_MUL;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MUL:  state_nxt = ST_DONE;
            ST_DIV:  state_nxt = div_last ? ST_FIX : ST_DIV;
            ST_FIX:  state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    // The op is captured on accept; later changes on the inputs are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fn_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            rd_q <= '0;
        end else if (accept) begin
            fn_q <= func3;
            a_q  <= op1;
            b_q  <= op2;
            rd_q <= rd_in;
        end
    end

    muldiv_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load_div),
        .step      (state == ST_DIV),
        .dividend  (mag1),
        .divisor   (mag2),
        .quotient  (quotient),
        .remainder (remainder),
        .last      (div_last)
    );

    // Operands are extended to 2*XLEN according to their signedness; the low
    // 2*XLEN bits of an unsigned product are then correct for every variant.
    always_comb begin
        a_sx    = (fn_q[1:0] != 2'b11) && a_q[XLEN-1];
        b_sx    = !fn_q[1] && b_q[XLEN-1];
        a_w     = {{XLEN{a_sx}}, a_q};
        b_w     = {{XLEN{b_sx}}, b_q};
        prod    = a_w * b_w;
        mul_res = (fn_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Only bypassed divides reach the MUL slot: a zero divisor or the
    // most-negative / -1 overflow.
    always_comb begin
        if (b_q == '0) begin
            corner_res = fn_q[1] ? a_q : '1;
        end else begin
            corner_res = fn_q[1] ? '0 : a_q;
        end
    end

    // Quotient takes the xor of operand signs, remainder the dividend's sign.
    always_comb begin
        neg_q = !fn_q[0] && (a_q[XLEN-1] ^ b_q[XLEN-1]);
        neg_r = !fn_q[0] && a_q[XLEN-1];
        if (fn_q[1]) begin
            fix_res = neg_r ? -remainder : remainder;
        end else begin
            fix_res = neg_q ? -quotient : quotient;
        end
    end

    // result/rd_out are written on the edge that enters DONE and hold
    // otherwise; a flushed op never reaches them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            rd_out <= '0;
        end else if (!flush) begin
            if (state == ST_MUL) begin
                result <= fn_q[2] ? corner_res : mul_res;
                rd_out <= rd_q;
            end else if (state == ST_FIX) begin
                result <= fix_res;
                rd_out <= rd_q;
            end
        end
    end

    assign busy = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit. Expected results come from a
// behavioural model using native SystemVerilog arithmetic and are queued when
// an op is driven, then popped when done is observed.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      func3 = '0;
    logic [XLEN-1:0] op1 = '0;
    logic [XLEN-1:0] op2 = '0;
    logic [RD_W-1:0] rd_in = '0;
    logic            flush = 1'b0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_out;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
    } op_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    muldiv_unit #(
        .XLEN (XLEN),
        .RD_W (RD_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .op1    (op1),
        .op2    (op2),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    // Reference model: RV32M semantics from native 64-bit and signed ops.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            FN_MUL:    begin p = sa * sb; return p[31:0];  end
            FN_MULH:   begin p = sa * sb; return p[63:32]; end
            FN_MULHSU: begin p = sa * ub; return p[63:32]; end
            FN_MULHU:  begin p = ua * ub; return p[63:32]; end
            FN_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            FN_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            FN_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
        if (!f[2]) return 2;
        if (b == 0) return 2;
        if (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
        return XLEN + 2;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        last_res = e.res;
        last_rd  = e.rd;
        return e;
    endfunction

    // Drive a request at the current negedge and queue its expected result.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        func3 = f;
        op1   = a;
        op2   = b;
        rd_in = rd;
        start = 1'b1;
        e.res = model(f, a, b);
        e.rd  = rd;
        exp_q.push_back(e);
    endtask

    task automatic send_op(input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        applyStimulus(f, a, b, rd);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle 1; returns the cycle in which done is
    // seen (or -1) and whether busy was high in every cycle before it.
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
        vectors++; if (result !== '0) begin miscompares++; $display("[TB] FAIL reset_result got %h want 0", result); end
        vectors++; if (rd_out !== '0) begin miscompares++; $display("[TB] FAIL reset_rd got %h want 0", rd_out); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        op_t  tbl[4];
        op_t  t;
        exp_t e;
        int   cyc;
        bit   bok;
        tbl[0] = '{FN_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1] = '{FN_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006};
        tbl[2] = '{FN_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[3] = '{FN_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 10; i++) begin
            if (i < 4) t = tbl[i];
            else t = '{3'($urandom_range(0, 3)), $urandom, $urandom, 32'h0};
            send_op(t.f, t.a, t.b, 5'(i + 1));
            wait_done(cyc, bok);
            e = pop_exp();
            vectors++; if (cyc != 2) begin miscompares++; $display("[TB] FAIL mul_latency[%0d] got %0d want 2", i, cyc); end
            vectors++; if (result !== e.res) begin miscompares++; $display("[TB] FAIL mul_result[%0d] f=%0d got %h want %h", i, t.f, result, e.res); end
            vectors++; if (rd_out !== e.rd) begin miscompares++; $display("[TB] FAIL mul_rd[%0d] got %0d want %0d", i, rd_out, e.rd); end
            if (i < 4) begin
                vectors++; if (result !== t.want) begin miscompares++; $display("[TB] FAIL mul_plan[%0d] got %h want %h", i, result, t.want); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div();
        op_t  tbl[5];
        op_t  t;
        exp_t e;
        int   cyc;
        int   lat;
        bit   bok;
        tbl[0] = '{FN_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        tbl[1] = '{FN_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        tbl[2] = '{FN_DIVU, 32'd100,       32'd7,         32'd14};
        tbl[3] = '{FN_REMU, 32'd100,       32'd7,         32'd2};
        tbl[4] = '{FN_DIV,  32'd0,         32'd5,         32'd0};
        for (int i = 0; i < 13; i++) begin
            if (i < 5) t = tbl[i];
            else t = '{3'($urandom_range(4, 7)), $urandom, 32'($urandom_range(1, 32'hFFFF)) ^ (i[0] ? 32'hFFFF_0000 : 32'h0), 32'h0};
            lat = model_latency(t.f, t.a, t.b);
            send_op(t.f, t.a, t.b, 5'(i + 10));
            wait_done(cyc, bok);
            e = pop_exp();
            vectors++; if (cyc != lat) begin miscompares++; $display("[TB] FAIL div_latency[%0d] got %0d want %0d", i, cyc, lat); end
            vectors++; if (!bok) begin miscompares++; $display("[TB] FAIL div_busy[%0d] got low want high before done", i); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL div_busy_done[%0d] got %b want 0", i, busy); end
            vectors++; if (result !== e.res) begin miscompares++; $display("[TB] FAIL div_result[%0d] f=%0d a=%h b=%h got %h want %h", i, t.f, t.a, t.b, result, e.res); end
            vectors++; if (rd_out !== e.rd) begin miscompares++; $display("[TB] FAIL div_rd[%0d] got %0d want %0d", i, rd_out, e.rd); end
            if (i < 5) begin
                vectors++; if (result !== t.want) begin miscompares++; $display("[TB] FAIL div_plan[%0d] got %h want %h", i, result, t.want); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_corner();
        op_t  tbl[6];
        exp_t e;
        int   cyc;
        bit   bok;
        tbl[0] = '{FN_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF};
        tbl[1] = '{FN_REM,  32'd5,         32'd0,         32'd5};
        tbl[2] = '{FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[3] = '{FN_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        tbl[4] = '{FN_DIV,  32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFFF};
        tbl[5] = '{FN_REMU, 32'h0000_1234, 32'd0,         32'h0000_1234};
        for (int i = 0; i < 6; i++) begin
            send_op(tbl[i].f, tbl[i].a, tbl[i].b, 5'(i + 20));
            wait_done(cyc, bok);
            e = pop_exp();
            vectors++; if (cyc != 2) begin miscompares++; $display("[TB] FAIL corner_latency[%0d] got %0d want 2", i, cyc); end
            vectors++; if (result !== tbl[i].want) begin miscompares++; $display("[TB] FAIL corner_plan[%0d] got %h want %h", i, result, tbl[i].want); end
            vectors++; if (result !== e.res) begin miscompares++; $display("[TB] FAIL corner_result[%0d] got %h want %h", i, result, e.res); end
            vectors++; if (rd_out !== e.rd) begin miscompares++; $display("[TB] FAIL corner_rd[%0d] got %0d want %0d", i, rd_out, e.rd); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        int   extra;
        bit   bok;
        // start held high through the whole divide is accepted only once
        applyStimulus(FN_DIVU, 32'd1000, 32'd3, 5'd3);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 60);
        start = 1'b0;
        e = pop_exp();
        vectors++; if (cyc != XLEN + 2) begin miscompares++; $display("[TB] FAIL held_latency got %0d want %0d", cyc, XLEN + 2); end
        vectors++; if (result !== e.res) begin miscompares++; $display("[TB] FAIL held_result got %h want %h", result, e.res); end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        vectors++; if (extra != 0) begin miscompares++; $display("[TB] FAIL held_reissue got %0d active cycles want 0", extra); end

        // new start in the DONE cycle is accepted with no bubble
        send_op(FN_MUL, 32'd3, 32'd4, 5'd5);
        wait_done(cyc, bok);
        applyStimulus(FN_MUL, 32'd100, 32'hFFFF_FFFE, 5'd9);
        e = pop_exp();
        vectors++; if (result !== e.res) begin miscompares++; $display("[TB] FAIL b2b_first_result got %h want %h", result, e.res); end
        vectors++; if (rd_out !== 5'd5) begin miscompares++; $display("[TB] FAIL b2b_first_rd got %0d want 5", rd_out); end
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bok);
        applyStimulus(FN_DIVU, 32'd77, 32'd5, 5'd17);
        e = pop_exp();
        vectors++; if (cyc != 2) begin miscompares++; $display("[TB] FAIL b2b_second_latency got %0d want 2", cyc); end
        vectors++; if (result !== e.res) begin miscompares++; $display("[TB] FAIL b2b_second_result got %h want %h", result, e.res); end
        vectors++; if (rd_out !== 5'd9) begin miscompares++; $display("[TB] FAIL b2b_second_rd got %0d want 9", rd_out); end
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bok);
        e = pop_exp();
        vectors++; if (cyc != XLEN + 2) begin miscompares++; $display("[TB] FAIL b2b_div_latency got %0d want %0d", cyc, XLEN + 2); end
        vectors++; if (result !== e.res) begin miscompares++; $display("[TB] FAIL b2b_div_result got %h want %h", result, e.res); end
        vectors++; if (rd_out !== 5'd17) begin miscompares++; $display("[TB] FAIL b2b_div_rd got %0d want 17", rd_out); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int ndone;
        send_op(FN_DIV, 32'hFFFF_FF9C, 32'd3, 5'd12);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(exp_q.pop_back());
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_busy got %b want 0", busy); end
        ndone = 0;
        repeat (40) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        vectors++; if (ndone != 0) begin miscompares++; $display("[TB] FAIL flush_done got %0d pulses want 0", ndone); end
        vectors++; if (result !== last_res) begin miscompares++; $display("[TB] FAIL flush_result got %h want %h", result, last_res); end
        vectors++; if (rd_out !== last_rd) begin miscompares++; $display("[TB] FAIL flush_rd got %0d want %0d", rd_out, last_rd); end
    endtask

    task automatic test_reset_mid_div();
        exp_t e;
        int   cyc;
        bit   bok;
        send_op(FN_DIV, 32'd12345, 32'd6, 5'd21);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        void'(exp_q.pop_back());
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_done got %b want 0", done); end
        vectors++; if (result !== '0) begin miscompares++; $display("[TB] FAIL rstmid_result got %h want 0", result); end
        vectors++; if (rd_out !== '0) begin miscompares++; $display("[TB] FAIL rstmid_rd got %0d want 0", rd_out); end
        @(negedge clk);
        rst = 1'b1;
        last_res = '0;
        last_rd  = '0;
        @(negedge clk);
        send_op(FN_MUL, 32'd6, 32'd7, 5'd1);
        wait_done(cyc, bok);
        e = pop_exp();
        vectors++; if (cyc != 2) begin miscompares++; $display("[TB] FAIL rstmid_recover_latency got %0d want 2", cyc); end
        vectors++; if (result !== 32'd42) begin miscompares++; $display("[TB] FAIL rstmid_recover_result got %h want 2a", result); end
        vectors++; if (rd_out !== e.rd) begin miscompares++; $display("[TB] FAIL rstmid_recover_rd got %0d want %0d", rd_out, e.rd); end
        @(negedge clk);
    endtask

    task automatic test_flush_start();
        exp_t e;
        int   cyc;
        int   ndone;
        bit   bok;
        // flush and start together: the start is dropped
        func3 = FN_MUL; op1 = 32'd2; op2 = 32'd3; rd_in = 5'd7;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fs_busy got %b want 0", busy); end
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        vectors++; if (ndone != 0) begin miscompares++; $display("[TB] FAIL fs_done got %0d pulses want 0", ndone); end
        vectors++; if (result !== last_res) begin miscompares++; $display("[TB] FAIL fs_result got %h want %h", result, last_res); end

        // flush in the DONE cycle: the pulse stands, the new start is dropped
        send_op(FN_MUL, 32'd9, 32'd9, 5'd4);
        wait_done(cyc, bok);
        e = pop_exp();
        vectors++; if (cyc != 2) begin miscompares++; $display("[TB] FAIL fdone_latency got %0d want 2", cyc); end
        vectors++; if (result !== 32'd81) begin miscompares++; $display("[TB] FAIL fdone_result got %h want 51", result); end
        func3 = FN_MULHU; op1 = 32'd5; op2 = 32'd5; rd_in = 5'd8;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL fdone_after got busy=%b done=%b want 0 0", busy, done); end
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        vectors++; if (ndone != 0) begin miscompares++; $display("[TB] FAIL fdone_extra got %0d pulses want 0", ndone); end
        vectors++; if (result !== e.res || rd_out !== e.rd) begin miscompares++; $display("[TB] FAIL fdone_hold got %h/%0d want %h/%0d", result, rd_out, e.res, e.rd); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_corner();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        test_flush_start();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
